// File: rtl/acionador_pkg.sv
// Shared state encoding and default timing parameters for the PWM pattern driver.
package acionador_pkg;

  typedef enum logic [1:0] {
    StParado  = 2'd0,
    StGirando = 2'd1,
    StTroca   = 2'd2
  } estado_e;

  localparam int unsigned DIV_TICK_DEF     = 4;
  localparam int unsigned GUARDA_TICKS_DEF = 8;

endpackage

// File: rtl/divisor_tick.sv
// Prescaler: counts 0..DIV_TICK-1 and flags tick on the last count.
module divisor_tick #(
  parameter int unsigned DIV_TICK = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  logic [7:0] cnt_q, cnt_d;

  assign tick = (cnt_q == 8'(DIV_TICK - 1));

  always_comb begin
    cnt_d = cnt_q + 8'd1;
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/acionador_pwm.sv
// Serialises an 8-bit speed pattern onto one of four motor lines, with a
// dead-time guard between motor changes and frame-aligned updates.
module acionador_pwm
  import acionador_pkg::*;
#(
  parameter int unsigned DIV_TICK     = DIV_TICK_DEF,
  parameter int unsigned GUARDA_TICKS = GUARDA_TICKS_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] velocidade,
  input  logic [1:0] motor,
  input  logic       atualiza,
  output logic [3:0] saida_motor,
  output logic [1:0] motor_ativo,
  output logic       ocupado
);

  estado_e    estado_q, estado_d;
  logic [7:0] padrao_q, padrao_d;
  logic [1:0] motor_ativo_q, motor_ativo_d;
  logic [1:0] motor_troca_q, motor_troca_d;
  logic [2:0] indice_q, indice_d;
  logic [7:0] guarda_q, guarda_d;
  logic [7:0] pend_vel_q, pend_vel_d;
  logic [1:0] pend_mot_q, pend_mot_d;
  logic       pendente_q, pendente_d;
  logic       tick, clr, aplica;

  divisor_tick #(
    .DIV_TICK(DIV_TICK)
  ) u_divisor_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .tick (tick)
  );

  always_comb begin
    estado_d      = estado_q;
    padrao_d      = padrao_q;
    motor_ativo_d = motor_ativo_q;
    motor_troca_d = motor_troca_q;
    indice_d      = indice_q;
    guarda_d      = guarda_q;
    aplica        = 1'b0;

    unique case (estado_q)
      StParado: begin
        aplica = pendente_q;
      end
      StGirando: begin
        if (tick) begin
          indice_d = indice_q + 3'd1;
          // Updates only land on the 7->0 wrap so a frame is never cut short.
          aplica   = pendente_q && (indice_q == 3'd7);
        end
      end
      StTroca: begin
        if (tick) begin
          if (guarda_q == 8'd1) begin
            estado_d      = StGirando;
            motor_ativo_d = motor_troca_q;
            indice_d      = '0;
            guarda_d      = '0;
          end else begin
            guarda_d = guarda_q - 8'd1;
          end
        end
      end
      default: estado_d = StParado;
    endcase

    if (aplica) begin
      indice_d = '0;
      if (pend_vel_q == 8'd0) begin
        estado_d = StParado;
        padrao_d = '0;
      end else if (estado_q == StParado || pend_mot_q == motor_ativo_q) begin
        estado_d      = StGirando;
        padrao_d      = pend_vel_q;
        motor_ativo_d = pend_mot_q;
      end else begin
        // Output is forced low in TROCA, so the new pattern can be loaded early.
        estado_d      = StTroca;
        guarda_d      = 8'(GUARDA_TICKS);
        padrao_d      = pend_vel_q;
        motor_troca_d = pend_mot_q;
      end
    end

    clr = aplica && (estado_q == StParado);

    pend_vel_d = atualiza ? velocidade : pend_vel_q;
    pend_mot_d = atualiza ? motor : pend_mot_q;
    pendente_d = atualiza ? 1'b1 : (aplica ? 1'b0 : pendente_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q      <= StParado;
      padrao_q      <= '0;
      motor_ativo_q <= '0;
      motor_troca_q <= '0;
      indice_q      <= '0;
      guarda_q      <= '0;
      pend_vel_q    <= '0;
      pend_mot_q    <= '0;
      pendente_q    <= 1'b0;
    end else begin
      estado_q      <= estado_d;
      padrao_q      <= padrao_d;
      motor_ativo_q <= motor_ativo_d;
      motor_troca_q <= motor_troca_d;
      indice_q      <= indice_d;
      guarda_q      <= guarda_d;
      pend_vel_q    <= pend_vel_d;
      pend_mot_q    <= pend_mot_d;
      pendente_q    <= pendente_d;
    end
  end

  always_comb begin
    saida_motor = '0;
    if (estado_q == StGirando) saida_motor[motor_ativo_q] = padrao_q[indice_q];
  end

  assign motor_ativo = motor_ativo_q;
  assign ocupado     = (estado_q != StParado) || pendente_q;

endmodule

// File: tb/tb_acionador_pwm.sv
// Directed and random stimulus for acionador_pwm, checked every cycle against a
// clock-counting reference model of the pattern/guard timing.
module tb_acionador_pwm;

  localparam int DIV    = 4;
  localparam int GUARDA = 8;
  localparam int FRAME  = 8 * DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] velocidade = '0;
  logic [1:0] motor = '0;
  logic       atualiza = 1'b0;
  logic [3:0] saida_motor;
  logic [1:0] motor_ativo;
  logic       ocupado;

  int n_checks = 0;
  int n_err = 0;

  acionador_pwm #(
    .DIV_TICK    (DIV),
    .GUARDA_TICKS(GUARDA)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .velocidade (velocidade),
    .motor      (motor),
    .atualiza   (atualiza),
    .saida_motor(saida_motor),
    .motor_ativo(motor_ativo),
    .ocupado    (ocupado)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 stopped, 1 running, 2 dead-time.
  // m_t counts clocks since the frame start; m_left counts remaining dead-time clocks.
  int         m_mode, m_t, m_left;
  logic [7:0] m_pat, m_new_pat, m_pvel;
  logic [1:0] m_mot, m_new_mot, m_pmot;
  bit         m_pend;

  task automatic model_reset();
    m_mode = 0; m_t = 0; m_left = 0;
    m_pat = 0; m_new_pat = 0; m_pvel = 0;
    m_mot = 0; m_new_mot = 0; m_pmot = 0;
    m_pend = 0;
  endtask

  task automatic model_step();
    bit ap;
    bit was_stop;
    if (!rst_n) begin
      model_reset();
      return;
    end
    ap = 0;
    was_stop = (m_mode == 0);
    if (m_mode == 0) begin
      ap = m_pend;
    end else if (m_mode == 1) begin
      m_t = m_t + 1;
      if (m_t == FRAME) begin
        m_t = 0;
        ap = m_pend;
      end
    end else begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_mode = 1; m_pat = m_new_pat; m_mot = m_new_mot; m_t = 0;
      end
    end
    if (ap) begin
      if (m_pvel == 0) begin
        m_mode = 0; m_pat = 0; m_t = 0;
      end else if (was_stop || m_pmot == m_mot) begin
        m_mode = 1; m_pat = m_pvel; m_mot = m_pmot; m_t = 0;
      end else begin
        m_mode = 2; m_left = GUARDA * DIV; m_new_pat = m_pvel; m_new_mot = m_pmot;
      end
    end
    if (atualiza) begin
      m_pvel = velocidade; m_pmot = motor; m_pend = 1;
    end else if (ap) begin
      m_pend = 0;
    end
  endtask

  function automatic logic [7:0] exp_saida();
    logic [3:0] s;
    s = '0;
    if (m_mode == 1 && m_pat[m_t / DIV]) s[m_mot] = 1'b1;
    return {4'b0, s};
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("saida_motor", {4'b0, saida_motor}, exp_saida());
    chk("motor_ativo", {6'b0, motor_ativo}, {6'b0, m_mot});
    chk("ocupado", {7'b0, ocupado}, {7'b0, (m_mode != 0 || m_pend)});
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic strobe(input logic [7:0] v, input logic [1:0] m);
    velocidade = v; motor = m; atualiza = 1'b1;
    cyc();
    atualiza = 1'b0;
  endtask

  initial begin
    bit ok;
    model_reset();
    run(3);
    chk("reset_saida", {4'b0, saida_motor}, 8'h00);
    chk("reset_ocupado", {7'b0, ocupado}, 8'h00);
    rst_n = 1'b1;
    run(5);

    // Start from idle: pattern bit 0 visible right after the apply edge.
    strobe(8'h0F, 2'd2);
    cyc();
    chk("start_bit0", {4'b0, saida_motor}, 8'h04);
    chk("start_motor", {6'b0, motor_ativo}, 8'h02);
    run(70);

    // Same-motor change requested at indice 3.
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (m_t == 3 * DIV) ok = 1;
      else cyc();
    end
    chk("wait_indice3", {7'b0, ok}, 8'h01);
    strobe(8'h33, 2'd2);
    run(80);

    // Move to motor 0, then swap to motor 3 with dead time.
    strobe(8'h55, 2'd0);
    run(110);
    strobe(8'hC3, 2'd3);
    run(110);
    chk("swap_motor3", {6'b0, motor_ativo}, 8'h03);

    // Back-to-back strobes mid-frame: last one wins.
    run(7);
    strobe(8'h0F, 2'd3);
    strobe(8'h33, 2'd3);
    run(80);

    // Stop at the next frame boundary.
    strobe(8'h00, 2'd3);
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (m_mode == 0) ok = 1;
      else cyc();
    end
    chk("stop_reached", {7'b0, ok}, 8'h01);
    chk("stop_ocupado", {7'b0, ocupado}, 8'h00);
    chk("stop_saida", {4'b0, saida_motor}, 8'h00);

    // Random strobes.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        strobe(($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255)),
               2'($urandom_range(0, 3)));
      end else begin
        cyc();
      end
    end

    // Asynchronous reset in the middle of a dead-time interval.
    strobe(8'hFF, 2'd0);
    run(40);
    strobe(8'hAA, 2'd1);
    ok = 0;
    for (int i = 0; i < 80 && !ok; i++) begin
      if (m_mode == 2) ok = 1;
      else cyc();
    end
    chk("troca_reached", {7'b0, ok}, 8'h01);
    strobe(8'h5A, 2'd2);
    run(5);
    @(posedge clk);
    model_step();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_saida", {4'b0, saida_motor}, 8'h00);
    chk("async_motor", {6'b0, motor_ativo}, 8'h00);
    chk("async_ocupado", {7'b0, ocupado}, 8'h00);
    @(negedge clk);
    check_all();
    run(2);
    rst_n = 1'b1;
    run(60);
    chk("idle_after_reset", {4'b0, saida_motor}, 8'h00);
    strobe(8'h81, 2'd1);
    run(40);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/acionador_pwm.md
ACIONADOR_PWM -- requirements
Module: acionador_pwm

Interface
REQ-001 The block SHALL have parameter DIV_TICK, default 4, meaning clocks per pattern bit (legal 2..255).
REQ-002 The block SHALL have parameter GUARDA_TICKS, default 8, meaning dead-time ticks, all outputs low, between motor changes (legal 1..255).
REQ-003 The block SHALL have port clk  input  1  the single system clock, rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port velocidade  input  8  speed pattern from the speed/motor selector; bit 0 is sent first.
REQ-006 The block SHALL have port motor  input  2  target motor index 0..3.
REQ-007 The block SHALL have port atualiza  input  1  one-cycle strobe that captures velocidade and motor.
REQ-008 The block SHALL have port saida_motor  output  4  drive lines, one per motor; at most one bit is ever high.
REQ-009 The block SHALL have port motor_ativo  output  2  index of the motor currently owning the output.
REQ-010 The block SHALL have port ocupado  output  1  high while the state is not PARADO or an update is pending.

Function
REQ-011 Capture: on a clk edge with atualiza=1, velocidade and motor SHALL be copied into pending registers and pendente set to 1; a later strobe before apply SHALL overwrite them (last wins).
REQ-012 Tick: a prescaler SHALL count 0..DIV_TICK-1 and assert tick when the count is DIV_TICK-1; each tick advances indice (3 bits), and indice wraps 7 to 0.
REQ-013 Frame boundary: a frame boundary SHALL be the tick on which indice wraps 7 to 0.
REQ-014 States SHALL be PARADO, GIRANDO and TROCA.
REQ-015 PARADO: all saida_motor SHALL be 0; if pendente=1, the next edge SHALL apply the pending value, clear pendente, reset the prescaler and set indice=0.
REQ-016 Apply, pattern 0: the state SHALL go to PARADO, padrao=0, and motor_ativo SHALL be unchanged.
REQ-017 Apply, nonzero pattern, same motor or from PARADO: padrao SHALL load, motor_ativo SHALL load, and the state SHALL go to GIRANDO.
REQ-018 Apply, nonzero pattern, different motor while GIRANDO: the state SHALL go to TROCA and the guard counter SHALL load GUARDA_TICKS.
REQ-019 GIRANDO: saida_motor[motor_ativo] SHALL equal padrao[indice], with all other bits 0; pending updates SHALL be applied only at a frame boundary, never mid-frame.
REQ-020 TROCA: saida_motor SHALL be 0; the guard counter SHALL decrement per tick; on reaching 0 the block SHALL load the new padrao and motor_ativo, set indice=0, and go to GIRANDO.
REQ-021 A strobe during TROCA SHALL update only the pending registers; it SHALL be applied at the first frame boundary after TROCA completes.
REQ-022 A strobe coincident with an apply edge SHALL be captured as a new pending value; the apply SHALL use the previously pending value.
REQ-023 Latency: for a strobe at edge E0 in PARADO, the apply SHALL occur at E1, with padrao[0] visible on saida_motor immediately after E1.
REQ-024 saida_motor SHALL be decoded only from registered state, indice, padrao and motor_ativo, with no combinational path from the inputs.

Reset
REQ-025 rst_n=0 SHALL asynchronously force the state to PARADO, and SHALL clear padrao, pendente, indice, the prescaler and the guard counter to 0.
REQ-026 rst_n=0 SHALL asynchronously force motor_ativo=0, saida_motor=0 and ocupado=0.
REQ-027 Reset mid-frame or mid-TROCA SHALL discard all pending data; after release the block SHALL be idle until the next strobe.

Structure
REQ-028 State encoding and the default DIV_TICK and GUARDA_TICKS SHALL live in shared package acionador_pkg.
REQ-029 The prescaler SHALL be sub-module divisor_tick (ports clk, rst_n, clr, tick; parameter DIV_TICK).
REQ-030 The implementation SHALL contain no other sub-modules.

Verification
REQ-031 Bench SHALL cover start: in PARADO, strobe velocidade=0x0F, motor=2 -> saida_motor[2] high 16 clocks then low 16 clocks, repeating; other bits 0; motor_ativo=2; ocupado=1.
REQ-032 Bench SHALL cover same-motor change: while running 0x0F on motor 2, strobe velocidade=0x33 at indice=3 -> the 0x0F frame completes unchanged, then output is 1,1,0,0,1,1,0,0 per 4-clock tick.
REQ-033 Bench SHALL cover motor change: while running motor 0, strobe motor=3, velocidade=0xC3 -> at the frame boundary saida_motor=0 for 32 clocks (8 ticks x 4), then saida_motor[3] follows 0xC3 and motor_ativo=3.
REQ-034 Bench SHALL cover stop: while running, strobe velocidade=0x00 -> stops at the next frame boundary; saida_motor=0 and ocupado=0 one clock later.
REQ-035 Bench SHALL cover overwrite: in GIRANDO, strobes 0x0F then 0x33 on consecutive clocks mid-frame -> only 0x33 is applied at the boundary.
REQ-036 Bench SHALL cover reset: rst_n=0 mid-TROCA -> all outputs 0 immediately (asynchronous); no output activity after release until a new strobe.
